average_threshold_checker: RTL and testbench

Sequential, parametrised average comparator. Accepts a stream of `COUNT` unsigned samples over a valid/ready handshake and accumulates their sum. It then computes the floor average with a bit-serial restoring divider and flags whether that average meets a programmable threshold. It replaces the fixed three-input, 4-bit combinational comparator with a handshaked block for the sensor/grading datapath that may be stalled from either side.

---
 rtl/average_threshold_checker.sv | 106 ++++++++++
 tb/tb_average_threshold_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/average_threshold_checker.sv
// Handshaked average comparator: accumulates COUNT samples, divides the sum
// bit-serially by COUNT and flags whether the floor average reaches THRESHOLD.
module average_threshold_checker #(
  parameter  int WIDTH     = 4,
  parameter  int COUNT     = 3,
  parameter  int THRESHOLD = 6,
  localparam int SW        = WIDTH + $clog2(COUNT),
  localparam int CW        = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_avg,
  output logic [SW-1:0]    out_rem,
  output logic             out_pass,
  output logic             busy
);

  localparam int SW1 = SW + 1;
  localparam int BW  = $clog2(SW + 1);
  localparam logic [SW:0] DIVISOR = SW1'(COUNT);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  state_t         state, state_nx;
  logic [SW-1:0]  sum;
  logic [SW-1:0]  prem;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bcnt;
  logic           accept, last_smp, last_bit, ge;
  logic [SW:0]    trial;
  logic [SW-1:0]  prem_nx, quo_nx;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != ACCUM);

  assign accept   = in_valid && (state == ACCUM);
  assign last_smp = (cnt == CW'(COUNT - 1));
  assign last_bit = (bcnt == BW'(SW - 1));

  // The sum register doubles as the dividend/quotient shift register:
  // its MSB feeds the partial remainder while quotient bits enter at the LSB.
  assign trial   = {prem, sum[SW-1]};
  assign ge      = (trial >= DIVISOR);
  assign prem_nx = ge ? SW'(trial - DIVISOR) : trial[SW-1:0];
  assign quo_nx  = (sum << 1) | SW'(ge);

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (accept && last_smp) state_nx = DIVIDE;
      DIVIDE:  if (last_bit)           state_nx = DONE;
      DONE:    if (out_ready)          state_nx = ACCUM;
      default:                         state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      prem     <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      out_avg  <= '0;
      out_rem  <= '0;
      out_pass <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          sum <= sum + SW'(in_data);
          if (last_smp) begin
            cnt  <= '0;
            prem <= '0;
            bcnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIVIDE: begin
          sum  <= quo_nx;
          prem <= prem_nx;
          bcnt <= bcnt + BW'(1);
          // Upper quotient bits are always zero, so only WIDTH bits are kept.
          if (last_bit) begin
            out_avg  <= quo_nx[WIDTH-1:0];
            out_rem  <= prem_nx;
            out_pass <= (quo_nx[WIDTH-1:0] >= WIDTH'(THRESHOLD));
          end
        end
        DONE: if (out_ready) sum <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_average_threshold_checker.sv
// Bench for average_threshold_checker: directed cases at default parameters
// plus random streams on WIDTH=8/COUNT=5 and COUNT=1 instances.
module tb_average_threshold_checker;

  int nvec = 0;
  int nerr = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance: WIDTH=4 COUNT=3 THRESHOLD=6, SW=6
  logic       in_valid = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic       in_ready, out_valid, out_pass, busy;
  logic [3:0] out_avg;
  logic [5:0] out_rem;

  average_threshold_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_avg(out_avg), .out_rem(out_rem),
    .out_pass(out_pass), .busy(busy));

  // WIDTH=8 COUNT=5 THRESHOLD=100, SW=11
  logic        b_in_valid = 0, b_out_ready = 0;
  logic [7:0]  b_in_data = 0;
  logic        b_in_ready, b_out_valid, b_out_pass, b_busy;
  logic [7:0]  b_out_avg;
  logic [10:0] b_out_rem;

  average_threshold_checker #(.WIDTH(8), .COUNT(5), .THRESHOLD(100)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_avg(b_out_avg), .out_rem(b_out_rem),
    .out_pass(b_out_pass), .busy(b_busy));

  // WIDTH=4 COUNT=1 THRESHOLD=6, SW=4
  logic       c_in_valid = 0, c_out_ready = 0;
  logic [3:0] c_in_data = 0;
  logic       c_in_ready, c_out_valid, c_out_pass, c_busy;
  logic [3:0] c_out_avg;
  logic [3:0] c_out_rem;

  average_threshold_checker #(.WIDTH(4), .COUNT(1), .THRESHOLD(6)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_avg(c_out_avg), .out_rem(c_out_rem),
    .out_pass(c_out_pass), .busy(c_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_avg", out_avg, 0);
    chk("rst_rem", out_rem, 0);
    chk("rst_pass", out_pass, 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk_reset();
  endtask

  task automatic send(input int d);
    int n = 0;
    @(negedge clk); in_valid = 1; in_data = 4'(d);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", n < 100, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_res(input int ea, input int er, input int ep);
    int lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
    chk("latency", lat, 7);
    chk("avg", out_avg, ea);
    chk("rem", out_rem, er);
    chk("pass", out_pass, ep);
  endtask

  task automatic consume();
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("in_ready_after_take", in_ready, 1);
    chk("out_valid_after_take", out_valid, 0);
  endtask

  task automatic stream3(input int a, input int b, input int c);
    int s = a + b + c;
    send(a); send(b); send(c);
    wait_res(s / 3, s % 3, (s / 3) >= 6);
    consume();
  endtask

  task automatic run_b();
    int s, n, sum = 0;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(90, 110));
      @(negedge clk); b_in_valid = 1; b_in_data = 8'(s); n = 0;
      while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1 b_in_valid = 0;
      sum += s;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!b_out_valid && n < 100);
    chk("b_latency", n, 12);
    chk("b_avg", b_out_avg, sum / 5);
    chk("b_rem", b_out_rem, sum % 5);
    chk("b_pass", b_out_pass, (sum / 5) >= 100);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    b_out_ready = 1;
    @(posedge clk); #1 b_out_ready = 0;
  endtask

  task automatic run_c();
    int s = $urandom_range(0, 15);
    int n = 0;
    @(negedge clk); c_in_valid = 1; c_in_data = 4'(s);
    while (!c_in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 c_in_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_out_valid && n < 100);
    chk("c_latency", n, 5);
    chk("c_avg", c_out_avg, s);
    chk("c_rem", c_out_rem, 0);
    chk("c_pass", c_out_pass, s >= 6);
    c_out_ready = 1;
    @(posedge clk); #1 c_out_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); chk_reset();

    stream3(7, 8, 6);
    stream3(4, 5, 5);
    stream3(6, 6, 6);
    stream3(5, 7, 5);
    stream3(15, 15, 15);
    stream3(0, 0, 0);

    // gaps between samples, then a held result with a sample offered during DONE
    send(3); repeat (2) @(negedge clk);
    send(9); @(negedge clk);
    send(6);
    wait_res(6, 0, 1);
    in_valid = 1; in_data = 4'd15;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
      chk("stall_avg", out_avg, 6);
      chk("stall_rem", out_rem, 0);
      chk("stall_pass", out_pass, 1);
      @(negedge clk);
    end
    in_valid = 0;
    consume();
    stream3(4, 5, 5);

    // aborted runs: after two samples, during divide, and in DONE with out_ready high
    send(12); send(13);
    pulse_rst();
    send(1); send(2); send(3);
    repeat (3) @(negedge clk);
    chk("busy_in_divide", busy, 1);
    pulse_rst();
    stream3(10, 10, 10);
    send(9); send(9); send(9);
    wait_res(9, 0, 1);
    out_ready = 1; rst = 1;
    @(posedge clk); #1 out_ready = 0; rst = 0;
    @(negedge clk); chk_reset();
    stream3(10, 10, 10);

    for (int i = 0; i < 20; i++)
      stream3($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));

    for (int i = 0; i < 1000; i++) run_b();
    for (int i = 0; i < 50; i++) run_c();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
